grid_scan: RTL and testbench
============================

GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 SHALL have parameter N, default 8, grid side length in cells (N x N grid).
REQ-002 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port _rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port grid_in, input, N*N, flattened cell matrix; bit r*N+c = cell (row r, col c), 1 = alive.
REQ-006 SHALL have port gen_tick, input, 1, one-cycle pulse: grid_in has just advanced one generation.
REQ-007 SHALL have port row_data, output, N, bits of the current row; bit c = col c.
REQ-008 SHALL have port row_idx, output, clog2(N), index of the row on row_data.
REQ-009 SHALL have port row_valid, output, 1, row_data/row_idx valid.
REQ-010 SHALL have port row_ready, input, 1, consumer accepts the row.
REQ-011 SHALL have port frame_last, output, 1, high with row_valid when row_idx = N-1.
REQ-012 SHALL have port pop_count, output, clog2(N*N+1), live-cell count of the last completed frame.
REQ-013 SHALL have port pop_valid, output, 1, one-cycle pulse: pop_count and still updated.
REQ-014 SHALL have port still, output, 1, last captured frame identical to the one captured before it.
REQ-015 SHALL have port gen_count, output, GEN_W, count of gen_tick pulses since reset.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port overrun, output, 1, sticky: a gen_tick was dropped.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, DONE.
REQ-019 IDLE with gen_tick=1: SHALL copy grid_in to the frame register, copy the old frame register to the previous-frame register, set row_idx=0, clear the popcount accumulator, and enter SEND; row_valid SHALL be high on the next cycle (1-cycle latency).
REQ-020 SEND: row_valid=1, row_data = frame row row_idx; a transfer SHALL occur only on a cycle with row_valid=1 and row_ready=1.
REQ-021 While row_valid=1 and row_ready=0, row_data, row_idx and frame_last SHALL hold stable.
REQ-022 Each transfer SHALL add the popcount of the transferred row to the accumulator; if row_idx<N-1, row_idx increments, else the FSM enters DONE.
REQ-023 DONE lasts exactly one cycle: row_valid=0, pop_valid=1, pop_count = accumulator total (0..N*N), still = (frame == previous frame); then IDLE.
REQ-024 pop_count and still SHALL hold their values until the next DONE cycle.
REQ-025 Every gen_tick pulse, in any state, SHALL increment gen_count, wrapping modulo 2^GEN_W.
REQ-026 A gen_tick in SEND or DONE SHALL NOT be captured, SHALL NOT disturb the frame in flight, and SHALL set overrun; overrun is cleared only by reset.
REQ-027 With row_ready held 1, a frame SHALL occupy N SEND cycles plus 1 DONE cycle; the earliest next capture is the cycle after DONE.
REQ-028 grid_in SHALL be sampled only on the capture cycle; changes at other times SHALL have no effect on the frame.

Reset
REQ-029 _rst=1 at a clock edge SHALL force state IDLE and set row_valid, row_idx, row_data, frame_last, pop_count, pop_valid, still, gen_count, busy and overrun to 0, and SHALL clear the frame and previous-frame registers to all zeros.
REQ-030 Reset SHALL override gen_tick and transfers in the same cycle; a reset mid-frame SHALL abandon the frame with no pop_valid pulse.
REQ-031 The first frame after reset SHALL be compared against an all-zero previous frame.

Verification
REQ-032 Reset: assert _rst 2 cycles with gen_tick=1 -> all outputs 0, gen_count=0, busy=0.
REQ-033 Blinker (row 3 = 0x1C, other rows 0), row_ready=1, one gen_tick -> rows 0..7 on 8 consecutive cycles, row 3 data 0x1C, frame_last only on row 7, then pop_valid with pop_count=3, still=0, gen_count=1.
REQ-034 Backpressure: row_ready=0 for 3 cycles while row_idx=2 -> row_data/row_idx held at row 2, pop_count still 3, and the frame takes 11 SEND cycles.
REQ-035 Identical 2x2 block grid captured twice -> second DONE gives still=1, pop_count=4; then a changed grid -> still=0.
REQ-036 gen_tick during SEND row 4 -> overrun=1 and stays 1, gen_count increments, frame data unchanged; full grid (all 1s) -> pop_count=64.
REQ-037 _rst during SEND row 5 -> row_valid=0 next cycle, no pop_valid; GEN_W=4 with 17 ticks -> gen_count=1.

Source files
------------

// File: rtl/grid_scan.sv
// grid_scan: captures an N x N cell grid on each generation tick and streams
// it out one row per handshake, then reports the frame's live-cell count and
// whether the frame is unchanged from the one captured before it.
module grid_scan #(
    parameter int N     = 8,
    parameter int GEN_W = 16
) (
    input  logic                       clk,
    input  logic                       _rst,
    input  logic [N*N-1:0]             grid_in,
    input  logic                       gen_tick,
    output logic [N-1:0]               row_data,
    output logic [$clog2(N)-1:0]       row_idx,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic                       frame_last,
    output logic [$clog2(N*N+1)-1:0]   pop_count,
    output logic                       pop_valid,
    output logic                       still,
    output logic [GEN_W-1:0]           gen_count,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N*N+1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t          state;
    logic [N*N-1:0]  frame;
    logic [N*N-1:0]  prev_frame;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [IW-1:0]   next_idx;
    logic            last_row;

    // Number of live cells in one row.
    function automatic logic [PW-1:0] row_pop(input logic [N-1:0] r);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + PW'(r[i]);
        end
        return s;
    endfunction

    // Running total including the row currently on offer, and the next row index.
    always_comb begin
        acc_next = acc + row_pop(row_data);
        next_idx = row_idx + IW'(1);
        last_row = (row_idx == IW'(N - 1));
    end

    // Frame capture, row streaming FSM, generation counter and sticky overrun.
    always_ff @(posedge clk) begin
        if (_rst) begin
            state      <= IDLE;
            frame      <= '0;
            prev_frame <= '0;
            acc        <= '0;
            row_data   <= '0;
            row_idx    <= '0;
            row_valid  <= 1'b0;
            frame_last <= 1'b0;
            pop_count  <= '0;
            pop_valid  <= 1'b0;
            still      <= 1'b0;
            gen_count  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (gen_tick) begin
                gen_count <= gen_count + GEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (gen_tick) begin
                        prev_frame <= frame;
                        frame      <= grid_in;
                        acc        <= '0;
                        row_idx    <= '0;
                        row_data   <= grid_in[N-1:0];
                        row_valid  <= 1'b1;
                        frame_last <= (N == 1);
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (gen_tick) begin
                        overrun <= 1'b1;
                    end
                    if (row_ready) begin
                        acc <= acc_next;
                        if (last_row) begin
                            row_valid  <= 1'b0;
                            frame_last <= 1'b0;
                            pop_count  <= acc_next;
                            pop_valid  <= 1'b1;
                            still      <= (frame == prev_frame);
                            state      <= DONE;
                        end else begin
                            row_idx    <= next_idx;
                            row_data   <= frame[32'(next_idx)*N +: N];
                            frame_last <= (next_idx == IW'(N - 1));
                        end
                    end
                end
                DONE: begin
                    if (gen_tick) begin
                        overrun <= 1'b1;
                    end
                    pop_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_scan.sv
// tb_grid_scan: table-driven and randomized checks of grid_scan against a
// frame-level model (expected rows are slices of the captured grid, popcount
// via $countones, still via comparison with the previously captured grid).
module tb_grid_scan;

    logic        clk;
    logic        _rst;
    logic [63:0] grid_in;
    logic        gen_tick;
    logic [7:0]  row_data;
    logic [2:0]  row_idx;
    logic        row_valid;
    logic        row_ready;
    logic        frame_last;
    logic [6:0]  pop_count;
    logic        pop_valid;
    logic        still;
    logic [15:0] gen_count;
    logic        busy;
    logic        overrun;

    logic        rst4;
    logic        tick4;
    logic [7:0]  row_data4;
    logic [2:0]  row_idx4;
    logic        row_valid4;
    logic        frame_last4;
    logic [6:0]  pop_count4;
    logic        pop_valid4;
    logic        still4;
    logic [3:0]  gen_count4;
    logic        busy4;
    logic        overrun4;

    int          errors;
    int          checks;
    int          gen_model;
    logic        ovr_model;
    logic [63:0] prev_model;

    typedef struct {
        logic [63:0] grid;
        int          mode;        // 0 ready=1, 1 random ready, 2 stall at row 2, 3 tick at row 4
        int          exp_pop;
        logic        exp_still;
        int          exp_cycles;  // -1 = do not check
    } vec_t;

    vec_t vecs[6];

    grid_scan #(.N(8), .GEN_W(16)) dut (
        .clk(clk), ._rst(_rst), .grid_in(grid_in), .gen_tick(gen_tick),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .frame_last(frame_last), .pop_count(pop_count),
        .pop_valid(pop_valid), .still(still), .gen_count(gen_count),
        .busy(busy), .overrun(overrun)
    );

    grid_scan #(.N(8), .GEN_W(4)) dut4 (
        .clk(clk), ._rst(rst4), .grid_in(grid_in), .gen_tick(tick4),
        .row_data(row_data4), .row_idx(row_idx4), .row_valid(row_valid4),
        .row_ready(1'b1), .frame_last(frame_last4), .pop_count(pop_count4),
        .pop_valid(pop_valid4), .still(still4), .gen_count(gen_count4),
        .busy(busy4), .overrun(overrun4)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counted, and reported on mismatch.
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Capture one grid and follow it through SEND and DONE, checking every cycle.
    task automatic apply_stimulus(input logic [63:0] g, input int mode, input int exp_pop,
                                  input logic exp_still, input int exp_cycles);
        int   r;
        int   cycles;
        int   stalls;
        logic rdy;
        logic injected;
        r = 0;
        cycles = 0;
        stalls = 0;
        injected = 1'b0;
        @(negedge clk);
        check_output("idle_before_capture", {63'd0, busy}, 64'd0);
        grid_in  = g;
        gen_tick = 1'b1;
        row_ready = 1'b1;
        @(negedge clk);
        gen_tick = 1'b0;
        gen_model++;
        while (r < 8 && cycles < 200) begin
            check_output("row_valid", {63'd0, row_valid}, 64'd1);
            check_output("row_idx", {61'd0, row_idx}, 64'(r));
            check_output("row_data", {56'd0, row_data}, 64'(g[r*8 +: 8]));
            check_output("frame_last", {63'd0, frame_last}, {63'd0, (r == 7)});
            check_output("busy_send", {63'd0, busy}, 64'd1);
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2 && r == 2 && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end
            if (mode == 3 && r == 4 && !injected) begin
                gen_tick = 1'b1;
                injected = 1'b1;
                gen_model++;
                ovr_model = 1'b1;
            end
            grid_in   = {$urandom, $urandom};
            row_ready = rdy;
            @(negedge clk);
            gen_tick = 1'b0;
            cycles++;
            if (rdy) r++;
        end
        row_ready = 1'b1;
        if (r < 8) check_output("frame_timeout", 64'(r), 64'd8);
        if (exp_cycles >= 0) check_output("send_cycles", 64'(cycles), 64'(exp_cycles));
        check_output("done_row_valid", {63'd0, row_valid}, 64'd0);
        check_output("done_pop_valid", {63'd0, pop_valid}, 64'd1);
        check_output("done_pop_count", {57'd0, pop_count}, 64'(exp_pop));
        check_output("done_still", {63'd0, still}, {63'd0, exp_still});
        check_output("done_busy", {63'd0, busy}, 64'd1);
        check_output("overrun", {63'd0, overrun}, {63'd0, ovr_model});
        check_output("gen_count", {48'd0, gen_count}, 64'(gen_model[15:0]));
        prev_model = g;
        @(negedge clk);
        check_output("after_done_pop_valid", {63'd0, pop_valid}, 64'd0);
        check_output("after_done_busy", {63'd0, busy}, 64'd0);
        check_output("pop_count_hold", {57'd0, pop_count}, 64'(exp_pop));
        check_output("still_hold", {63'd0, still}, {63'd0, exp_still});
    endtask

    // Test sequence: reset, directed table, random frames, mid-frame reset, GEN_W=4 wrap.
    initial begin
        logic [63:0] g;
        int          n;
        int          pulses;
        errors = 0;
        checks = 0;
        gen_model = 0;
        ovr_model = 1'b0;
        prev_model = '0;

        vecs[0] = '{64'h0000_0000_1C00_0000, 0, 3, 1'b0, 8};
        vecs[1] = '{64'h0000_0000_1C00_0000, 2, 3, 1'b1, 11};
        vecs[2] = '{64'h0000_0000_0000_0303, 0, 4, 1'b0, 8};
        vecs[3] = '{64'h0000_0000_0000_0303, 1, 4, 1'b1, -1};
        vecs[4] = '{64'h0000_0000_0000_0707, 0, 6, 1'b0, 8};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 3, 64, 1'b0, 8};

        _rst = 1'b1;
        rst4 = 1'b1;
        tick4 = 1'b0;
        gen_tick = 1'b1;
        row_ready = 1'b1;
        grid_in = {$urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        check_output("rst_row_valid", {63'd0, row_valid}, 64'd0);
        check_output("rst_row_idx", {61'd0, row_idx}, 64'd0);
        check_output("rst_row_data", {56'd0, row_data}, 64'd0);
        check_output("rst_frame_last", {63'd0, frame_last}, 64'd0);
        check_output("rst_pop", {57'd0, pop_count}, 64'd0);
        check_output("rst_pop_valid", {63'd0, pop_valid}, 64'd0);
        check_output("rst_still", {63'd0, still}, 64'd0);
        check_output("rst_gen_count", {48'd0, gen_count}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_overrun", {63'd0, overrun}, 64'd0);
        _rst = 1'b0;
        rst4 = 1'b0;
        gen_tick = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].grid, vecs[i].mode, vecs[i].exp_pop,
                           vecs[i].exp_still, vecs[i].exp_cycles);
        end

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) g = prev_model;
            else g = {$urandom, $urandom};
            apply_stimulus(g, 1, $countones(g), (g == prev_model), -1);
        end

        // Reset arriving while row 5 is on offer abandons the frame.
        @(negedge clk);
        grid_in = 64'h0123_4567_89AB_CDEF;
        gen_tick = 1'b1;
        @(negedge clk);
        gen_tick = 1'b0;
        n = 0;
        while (!(row_valid && row_idx == 3'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("reach_row5", {61'd0, row_idx}, 64'd5);
        _rst = 1'b1;
        @(negedge clk);
        _rst = 1'b0;
        check_output("midrst_row_valid", {63'd0, row_valid}, 64'd0);
        check_output("midrst_busy", {63'd0, busy}, 64'd0);
        check_output("midrst_gen_count", {48'd0, gen_count}, 64'd0);
        check_output("midrst_overrun", {63'd0, overrun}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (pop_valid) pulses++;
            @(negedge clk);
        end
        check_output("midrst_no_pop_valid", 64'(pulses), 64'd0);
        gen_model = 0;
        ovr_model = 1'b0;
        prev_model = '0;

        // First frame after reset compares against an all-zero previous frame.
        apply_stimulus(64'h0000_0000_1C00_0000, 0, 3, 1'b0, 8);

        // 17 ticks on the 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) begin
            tick4 = 1'b1;
            @(negedge clk);
        end
        tick4 = 1'b0;
        @(negedge clk);
        check_output("gen_w4_wrap", {60'd0, gen_count4}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
